div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
// - Multi-cycle sequencer for ALU_DIV/ALU_DIVU/ALU_REM/ALU_REMU in EX: a radix-2 restoring divider, one quotient bit per cycle.
// - Stalls the pipeline while busy and returns the result in the cycle its done flag is high.
// - Sits beside the ALU, keyed on alusel from the ALU control unit; all other alusel codes pass untouched.
// PARAMETERS
// - XLEN   32   operand/result width; iteration count = XLEN
// PORTS
// - clk         in   1     clock, rising edge
// - rst         in   1     reset, asynchronous, active-low
// - valid_i     in   1     EX stage holds a live instruction
// - alusel_i    in   5     ALU select from ALU control unit (`ALU_* codes)
// - flush_i     in   1     EX squash (branch/jump redirect)
// - dividend_i  in   XLEN  rs1 operand, held stable by pipeline while stall_o=1
// - divisor_i   in   XLEN  rs2 operand, held stable likewise
// - stall_o     out  1     freeze PC, IF/ID and ID/EX registers
// - done_o      out  1     result_o valid this cycle (one-cycle pulse)
// - result_o    out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)
// BEHAVIOUR
// - Reset: state=IDLE; stall_o=0, done_o=0, result_o=0, count=0, internal registers cleared.
// - start = valid_i & !flush_i & alusel_i in {DIV,DIVU,REM,REMU} & state==IDLE.
// - stall_o = start | (state==BUSY); combinational, so the accept cycle already stalls. stall_o=0 in DONE.
// - FSM:
//   - IDLE -> BUSY on start. Latch |operands|, sign flags, op type; count=0.
//   - IDLE -> DONE on start when divisor==0 or signed overflow (fast path, no iteration).
//   - BUSY -> BUSY while count<XLEN-1: one shift-subtract step per cycle, count++.
//   - BUSY -> DONE when count==XLEN-1, on the final step.
//   - DONE -> IDLE unconditionally. In DONE: done_o=1, result_o valid, start is ignored.
// - Latency: normal op done_o at accept+XLEN+1 (33 at default); fast path at accept+1.
// - Signed ops: divide magnitudes; quotient negated iff operand signs differ; remainder takes dividend sign.
// - RISC-V special cases, bit-exact:
//   - divide by 0: quotient = all ones; remainder = dividend.
//   - DIV/REM of 0x8000_0000 by -1: quotient = 0x8000_0000; remainder = 0.
// - result_o holds its last value outside DONE.
// - flush_i in BUSY or DONE: next edge -> IDLE, no done_o, count cleared. flush_i in the accept cycle: no start.
// - Async reset mid-operation: immediate return to reset values; the op is dropped.
// - MUL* and non-M codes: block stays IDLE with stall_o=0.
// CONFIGURATION
// - DIV_RESULT_CACHE_EN defined:
//   - On each completion (including fast path), store dividend, divisor, signedness, quotient, remainder; set cache_valid.
//   - start with identical dividend/divisor/signedness and cache_valid goes IDLE->DONE (done_o at accept+1) and serves the cached value for the requested op.
//   - This is the DIV-then-REM fusion case.
//   - cache_valid cleared only by reset; flush leaves it intact.
// - DIV_RESULT_CACHE_EN undefined: no cache storage; every non-special op takes the full XLEN+1 cycles.
// TESTING
// - DIVU 100/7: stall_o high cycles 0..32 -> done_o at cycle 33, result_o=14.
// - REM -7/2 -> result_o=0xFFFF_FFFF (-1). DIV -7/2 -> result_o=0xFFFF_FFFD (-3).
// - DIV 5/0 -> done_o at cycle 1, result_o=0xFFFF_FFFF. REMU 5/0 -> result_o=5.
// - DIV 0x8000_0000 / 0xFFFF_FFFF -> done_o at cycle 1, result_o=0x8000_0000. REM of the same -> result_o=0.
// - Flush path:
//   - DIVU 1000/3, flush_i at cycle 10 -> IDLE at cycle 11, no done_o, stall_o=0.
//   - Next DIVU 9/3 -> result_o=3 at accept+33.
// - Reset and cache:
//   - rst low at cycle 20 of an op -> stall_o=0 and done_o=0 immediately.
//   - With DIV_RESULT_CACHE_EN: DIV 100/7 then REM 100/7 -> second done_o at accept+1, result_o=2.

Source files
------------

// File: rtl/div_sequencer.sv
// Radix-2 restoring divide sequencer for DIV/DIVU/REM/REMU beside the EX-stage ALU; stalls while iterating.
// Optional DIV_RESULT_CACHE_EN keeps the last operands/results so a repeated operand pair completes in one cycle.
module div_sequencer #(
    parameter int         XLEN     = 32,
    parameter logic [4:0] ALU_DIV  = 5'd14,
    parameter logic [4:0] ALU_DIVU = 5'd15,
    parameter logic [4:0] ALU_REM  = 5'd16,
    parameter logic [4:0] ALU_REMU = 5'd17
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [4:0]      alusel_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic            neg_q, neg_r, is_rem;

    logic            is_div_op, start, in_sgn, in_rem, div0, ovf, hit, last;
    logic [XLEN-1:0] a_mag, b_mag, fast_q, fast_r, hq, hr, sp_q, sp_r;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] rem_n, q_n, fin_q, fin_r;

    // Reset gates start so a held valid_i cannot raise stall_o while rst is low.
    assign is_div_op = alusel_i inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    assign start     = rst && valid_i && !flush_i && is_div_op && (state == IDLE);
    assign stall_o   = start || (state == BUSY);

    assign in_sgn = (alusel_i == ALU_DIV) || (alusel_i == ALU_REM);
    assign in_rem = (alusel_i == ALU_REM) || (alusel_i == ALU_REMU);
    assign a_mag  = (in_sgn && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
    assign b_mag  = (in_sgn && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
    assign div0   = (divisor_i == '0);
    assign ovf    = in_sgn && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (&divisor_i);
    // Overflow quotient equals the dividend itself, so both special cases share one mux.
    assign fast_q = div0 ? '1 : dividend_i;
    assign fast_r = div0 ? dividend_i : '0;
    assign sp_q   = (div0 || ovf) ? fast_q : hq;
    assign sp_r   = (div0 || ovf) ? fast_r : hr;
    assign last   = (count == CW'(XLEN-1));

    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (!diff[XLEN]) begin
            rem_n = diff[XLEN-1:0];
            q_n   = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_n = rem_sh[XLEN-1:0];
            q_n   = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    assign fin_q = neg_q ? -q_n : q_n;
    assign fin_r = neg_r ? -rem_n : rem_n;

`ifdef DIV_RESULT_CACHE_EN
    logic            c_vld, c_sgn, op_sgn;
    logic [XLEN-1:0] c_a, c_b, c_q, c_r, op_a, op_b;

    assign hit = c_vld && (c_a == dividend_i) && (c_b == divisor_i) && (c_sgn == in_sgn);
    assign hq  = c_q;
    assign hr  = c_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_vld <= 1'b0; c_sgn <= 1'b0; op_sgn <= 1'b0;
            c_a <= '0; c_b <= '0; c_q <= '0; c_r <= '0;
            op_a <= '0; op_b <= '0;
        end else begin
            if (start) begin
                op_a <= dividend_i; op_b <= divisor_i; op_sgn <= in_sgn;
            end
            if (start && (div0 || ovf)) begin
                c_vld <= 1'b1; c_a <= dividend_i; c_b <= divisor_i; c_sgn <= in_sgn;
                c_q <= fast_q; c_r <= fast_r;
            end else if (state == BUSY && !flush_i && last) begin
                c_vld <= 1'b1; c_a <= op_a; c_b <= op_b; c_sgn <= op_sgn;
                c_q <= fin_q; c_r <= fin_r;
            end
        end
    end
`else
    assign hit = 1'b0;
    assign hq  = '0;
    assign hr  = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_rem   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    is_rem <= in_rem;
                    count  <= '0;
                    if (div0 || ovf || hit) begin
                        state    <= DONE;
                        done_o   <= 1'b1;
                        result_o <= in_rem ? sp_r : sp_q;
                    end else begin
                        state <= BUSY;
                        rem_q <= '0;
                        quo_q <= a_mag;
                        dvs_q <= b_mag;
                        neg_q <= in_sgn && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                        neg_r <= in_sgn && dividend_i[XLEN-1];
                    end
                end
                BUSY: if (flush_i) begin
                    state <= IDLE;
                    count <= '0;
                end else begin
                    rem_q <= rem_n;
                    quo_q <= q_n;
                    count <= count + 1'b1;
                    if (last) begin
                        state    <= DONE;
                        done_o   <= 1'b1;
                        result_o <= is_rem ? fin_r : fin_q;
                        count    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus random ops against an arithmetic model.
module tb_div_sequencer;
    localparam logic [4:0] DIV = 5'd14, DIVU = 5'd15, REM = 5'd16, REMU = 5'd17, MUL = 5'd10;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, flush_i;
    logic [4:0]  alusel_i;
    logic [31:0] dividend_i, divisor_i, result_o;
    logic        stall_o, done_o;

    int checks = 0;
    int errors = 0;

    // reference-side cache image and last delivered result
    bit          cv = 1'b0, cs = 1'b0;
    logic [31:0] ca = '0, cb = '0, last_res = '0;

    div_sequencer dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .alusel_i(alusel_i), .flush_i(flush_i),
        .dividend_i(dividend_i), .divisor_i(divisor_i),
        .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sg, rm;
        int sa, sb;
        logic [31:0] q, r;
        sg = (op == DIV) || (op == REM);
        rm = (op == REM) || (op == REMU);
        sa = a; sb = b;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0;
        end else if (sg) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
        return rm ? r : q;
    endfunction

    // Called at a negedge; drives one op and watches 36 cycles. flush_at<0 means no flush.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int flush_at);
        bit sg, special, hit, seen;
        int lat, dcyc, dcnt, scnt;
        logic [31:0] exp, res;
        sg      = (op == DIV) || (op == REM);
        special = (b == 0) || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hit     = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
        hit = cv && ca == a && cb == b && cs == sg;
`endif
        lat  = (special || hit) ? 1 : 33;
        exp  = model(op, a, b);
        alusel_i = op; dividend_i = a; divisor_i = b;
        dcyc = -1; dcnt = 0; scnt = 0; seen = 1'b0; res = '0;
        for (int c = 0; c < 36; c++) begin
            valid_i = !(seen || (flush_at >= 0 && c > flush_at));
            flush_i = (c == flush_at);
            #1;
            if (stall_o) scnt++;
            if (done_o) begin
                dcnt++;
                if (!seen) begin dcyc = c; res = result_o; end
                seen = 1'b1;
            end
            @(negedge clk);
        end
        valid_i = 1'b0; flush_i = 1'b0;
        if (flush_at >= 0) begin
            check({tag, ".done_cnt"}, dcnt, 0);
            check({tag, ".stall_cnt"}, scnt, flush_at + 1);
            check({tag, ".held"}, result_o, last_res);
        end else begin
            check({tag, ".done_cnt"}, dcnt, 1);
            check({tag, ".done_cyc"}, dcyc, lat);
            check({tag, ".stall_cnt"}, scnt, lat);
            check({tag, ".result"}, res, exp);
            check({tag, ".held"}, result_o, exp);
            last_res = exp;
            cv = 1'b1; ca = a; cb = b; cs = sg;
        end
    endtask

    // Ops that must never engage the sequencer.
    task automatic idle_op(input string tag, input logic [4:0] op, input logic fl);
        int scnt, dcnt;
        scnt = 0; dcnt = 0;
        valid_i = 1'b1; flush_i = fl; alusel_i = op;
        dividend_i = $urandom; divisor_i = $urandom_range(1, 1000);
        for (int c = 0; c < 4; c++) begin
            #1;
            if (stall_o) scnt++;
            if (done_o) dcnt++;
            @(negedge clk);
        end
        valid_i = 1'b0; flush_i = 1'b0;
        check({tag, ".stall"}, scnt, 0);
        check({tag, ".done"}, dcnt, 0);
    endtask

    initial begin
        logic [31:0] a, b, la, lb;
        logic [4:0]  op;
        logic [4:0]  ops [4];
        ops[0] = DIV; ops[1] = DIVU; ops[2] = REM; ops[3] = REMU;

        rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0; alusel_i = '0;
        dividend_i = '0; divisor_i = '0;
        repeat (2) @(negedge clk);
        check("reset.stall", stall_o, 0);
        check("reset.done", done_o, 0);
        check("reset.result", result_o, 0);
        rst = 1'b1;
        @(negedge clk);

        run_op("divu_100_7", DIVU, 100, 7, -1);
        check("divu_100_7.const", last_res, 14);
        run_op("rem_m7_2", REM, -32'sd7, 2, -1);
        check("rem_m7_2.const", last_res, 32'hFFFF_FFFF);
        run_op("div_m7_2", DIV, -32'sd7, 2, -1);
        check("div_m7_2.const", last_res, 32'hFFFF_FFFD);
        run_op("div_5_0", DIV, 5, 0, -1);
        run_op("remu_5_0", REMU, 5, 0, -1);
        check("remu_5_0.const", last_res, 5);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("divu_big", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("flush", DIVU, 1000, 3, 10);
        run_op("after_flush", DIVU, 9, 3, -1);
        run_op("div_100_7", DIV, 100, 7, -1);
        run_op("rem_100_7", REM, 100, 7, -1);
        check("rem_100_7.const", last_res, 2);
        run_op("remu_max", REMU, 32'hFFFF_FFFF, 32'h0001_0001, -1);
        run_op("div_neg_neg", DIV, -32'sd100, -32'sd9, -1);

        idle_op("mul", MUL, 1'b0);
        idle_op("nonm", 5'd3, 1'b0);
        idle_op("flush_accept", DIV, 1'b1);

        // async reset in the middle of an iteration
        valid_i = 1'b1; flush_i = 1'b0; alusel_i = DIVU; dividend_i = 1000; divisor_i = 3;
        repeat (20) @(negedge clk);
        #1;
        check("midrst.busy", stall_o, 1);
        rst = 1'b0;
        #1;
        check("midrst.stall", stall_o, 0);
        check("midrst.done", done_o, 0);
        check("midrst.result", result_o, 0);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cv = 1'b0; last_res = '0;
        @(negedge clk);

        la = 32'd12345; lb = 32'd67;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 3)];
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            case ($urandom_range(0, 9))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3: begin a = la; b = lb; end
                4: b = $urandom_range(1, 15);
                default: ;
            endcase
            run_op("rand", op, a, b, -1);
            la = a; lb = b;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
